// File: rtl/phy_arb_pkg.sv
// Shared types and default constants for the phy lane arbiter.
package phy_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF     = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int INIT_CYCLES_DEF = 16;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/phy_lane_arbiter_if.sv
// Requester-side valid/ready/data bundle: requesters are masters, the arbiter is the slave.
interface phy_lane_arbiter_if
    import phy_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/phy_lane_arbiter_rr_pick.sv
// Combinational circular-first picker: first set bit of req & ~excl starting at 'start'.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [IW-1:0] idx
);
    localparam logic [IW:0] N_L = (IW+1)'(N);

    logic [IW-1:0] cand_pos [N];
    logic [N-1:0]  cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum           = {1'b0, start} + (IW+1)'(gi);
            assign cand_pos[gi]  = (sum >= N_L) ? IW'(sum - N_L) : sum[IW-1:0];
            assign cand_hit[gi]  = req[cand_pos[gi]] & ~excl[cand_pos[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest candidate to 'start' wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                found = 1'b1;
                idx   = cand_pos[k];
            end
        end
    end
endmodule

// File: rtl/phy_lane_arbiter.sv
// Two-lane round-robin arbiter with IDLE/INIT/ACTIVE link bring-up.
// Define PHY_ARB_STATS_EN to build the saturating per-lane transfer counters.
module phy_lane_arbiter
    import phy_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
    input  logic                clk_f,
    input  logic                reset,
    input  logic                enable,
    input  logic                lane_pause,
    phy_lane_arbiter_if.slave   req_bus,
    output logic [DATA_W-1:0]   lane0_data,
    output logic                lane0_valid,
    output logic [DATA_W-1:0]   lane1_data,
    output logic                lane1_valid,
    output logic                active,
    output logic [CNT_W-1:0]    lane_cnt0,
    output logic [CNT_W-1:0]    lane_cnt1
);
    localparam int IW     = $clog2(NUM_REQ);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [IW:0]     N_L       = (IW+1)'(NUM_REQ);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    arb_state_e          state_reg, state_next;
    logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
    logic [IW-1:0]       ptr_reg, ptr_next;
    logic                active_reg;
    logic [DATA_W-1:0]   lane0_data_reg, lane1_data_reg;
    logic                lane0_valid_reg, lane1_valid_reg;

    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic                grant_en, found0, found1, take0, take1;
    logic [IW-1:0]       g0, g1, g1_start, last_idx;
    logic [IW:0]         g0_inc, last_inc;
    logic [NUM_REQ-1:0]  g0_mask, g1_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (!enable) begin
            state_next    = ST_IDLE;
            init_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_INIT;
                    init_cnt_next = '0;
                end
                ST_INIT: begin
                    if (init_cnt_reg == INIT_LAST) begin
                        state_next    = ST_ACTIVE;
                        init_cnt_next = '0;
                    end else begin
                        init_cnt_next = init_cnt_reg + 1'b1;
                    end
                end
                ST_ACTIVE: state_next = ST_ACTIVE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // enable is in the grant term so ready drops in the same cycle enable falls.
    assign grant_en = (state_reg == ST_ACTIVE) && enable && !lane_pause;

    rr_pick #(.N(NUM_REQ)) u_pick0 (
        .req   (req_bus.req_valid),
        .start (ptr_reg),
        .excl  ('0),
        .found (found0),
        .idx   (g0)
    );

    assign g0_inc   = {1'b0, g0} + 1'b1;
    assign g1_start = (g0_inc == N_L) ? '0 : g0_inc[IW-1:0];
    assign g0_mask  = NUM_REQ'(1) << g0;

    rr_pick #(.N(NUM_REQ)) u_pick1 (
        .req   (req_bus.req_valid),
        .start (g1_start),
        .excl  (g0_mask),
        .found (found1),
        .idx   (g1)
    );

    assign g1_mask = NUM_REQ'(1) << g1;
    assign take0   = grant_en && found0;
    assign take1   = take0 && found1;

    assign req_bus.req_ready = (take0 ? g0_mask : '0) | (take1 ? g1_mask : '0);

    assign last_idx = take1 ? g1 : g0;
    assign last_inc = {1'b0, last_idx} + 1'b1;
    assign ptr_next = (last_inc == N_L) ? '0 : last_inc[IW-1:0];

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            init_cnt_reg    <= '0;
            ptr_reg         <= '0;
            active_reg      <= 1'b0;
            lane0_data_reg  <= '0;
            lane1_data_reg  <= '0;
            lane0_valid_reg <= 1'b0;
            lane1_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            init_cnt_reg    <= init_cnt_next;
            active_reg      <= (state_next == ST_ACTIVE);
            lane0_valid_reg <= take0;
            lane1_valid_reg <= take1;
            if (take0) begin
                lane0_data_reg <= req_bytes[g0];
                ptr_reg        <= ptr_next;
            end
            if (take1) begin
                lane1_data_reg <= req_bytes[g1];
            end
        end
    end

    assign lane0_data  = lane0_data_reg;
    assign lane0_valid = lane0_valid_reg;
    assign lane1_data  = lane1_data_reg;
    assign lane1_valid = lane1_valid_reg;
    assign active      = active_reg;

`ifdef PHY_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_reg, cnt1_reg;

    // Counts advance on the edge that registers the lane valid, and clear on IDLE entry.
    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            cnt0_reg <= '0;
            cnt1_reg <= '0;
        end else if (state_next == ST_IDLE) begin
            cnt0_reg <= '0;
            cnt1_reg <= '0;
        end else begin
            if (take0 && (cnt0_reg != '1)) cnt0_reg <= cnt0_reg + 1'b1;
            if (take1 && (cnt1_reg != '1)) cnt1_reg <= cnt1_reg + 1'b1;
        end
    end

    assign lane_cnt0 = cnt0_reg;
    assign lane_cnt1 = cnt1_reg;
`else
    assign lane_cnt0 = '0;
    assign lane_cnt1 = '0;
`endif
endmodule

// File: tb/tb_phy_lane_arbiter.sv
// Directed bench for phy_lane_arbiter: bring-up, round-robin wrap, single requester, pause, disable, stats.
module tb_phy_lane_arbiter;
    import phy_arb_pkg::*;

    logic              clk_f;
    logic              reset;
    logic              enable;
    logic              lane_pause;
    logic [7:0]        lane0_data, lane1_data;
    logic              lane0_valid, lane1_valid;
    logic              active;
    logic [CNT_W-1:0]  lane_cnt0, lane_cnt1;

    int checks = 0;
    int errors = 0;

    phy_lane_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) req_bus ();

    phy_lane_arbiter #(.NUM_REQ(4), .DATA_W(8), .INIT_CYCLES(16)) dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .enable      (enable),
        .lane_pause  (lane_pause),
        .req_bus     (req_bus),
        .lane0_data  (lane0_data),
        .lane0_valid (lane0_valid),
        .lane1_data  (lane1_data),
        .lane1_valid (lane1_valid),
        .active      (active),
        .lane_cnt0   (lane_cnt0),
        .lane_cnt1   (lane_cnt1)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic check_lanes(input string tag, input logic [7:0] d0, input logic v0,
                               input logic [7:0] d1, input logic v1);
        check_val({tag, "_v0"}, 32'(lane0_valid), 32'(v0));
        if (v0) check_val({tag, "_d0"}, 32'(lane0_data), 32'(d0));
        check_val({tag, "_v1"}, 32'(lane1_valid), 32'(v1));
        if (v1) check_val({tag, "_d1"}, 32'(lane1_data), 32'(d1));
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        lane_pause = 1'b0;
        req_bus.req_valid = 4'b1111;
        req_bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset held with enable high
        repeat (3) tick();
        check_val("rst_ready",  32'(req_bus.req_ready), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        check_lanes("rst", 8'h00, 1'b0, 8'h00, 1'b0);
        check_val("rst_data0",  32'(lane0_data), 32'h0);
        check_val("rst_cnt0",   32'(lane_cnt0), 32'h0);

        // Bring-up: exactly 16 INIT cycles
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("init_active", 32'(active), 32'h0);
            check_val("init_ready",  32'(req_bus.req_ready), 32'h0);
        end
        tick();
        check_val("up_active", 32'(active), 32'h1);
        check_val("up_ready",  32'(req_bus.req_ready), 32'b0011);

        // Round-robin wrap with all four valid
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0) check_lanes("rr_a", 8'hA0, 1'b1, 8'hA1, 1'b1);
            else            check_lanes("rr_b", 8'hA2, 1'b1, 8'hA3, 1'b1);
            check_val("rr_ready", 32'(req_bus.req_ready), (k % 2 == 0) ? 32'b1100 : 32'b0011);
        end

        // Single requester 2, then requester 1 joins with ptr=3
        req_bus.req_valid = 4'b0100;
        req_bus.req_data  = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
        #1;
        check_val("single_ready", 32'(req_bus.req_ready), 32'b0100);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_lanes("single", 8'h5C, 1'b1, 8'h00, 1'b0);
            check_val("single_ready", 32'(req_bus.req_ready), 32'b0100);
        end
        req_bus.req_valid = 4'b0110;
        #1;
        check_val("wrap_ready", 32'(req_bus.req_ready), 32'b0110);
        tick();
        check_lanes("wrap", 8'hA1, 1'b1, 8'h5C, 1'b1);

        // Pause mid-stream, ptr=3 on entry
        req_bus.req_valid = 4'b1111;
        req_bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1;
        check_val("pre_pause_ready", 32'(req_bus.req_ready), 32'b1001);
        tick();
        check_lanes("pre_pause_a", 8'hA3, 1'b1, 8'hA0, 1'b1);
        check_val("pre_pause_ready", 32'(req_bus.req_ready), 32'b0110);
        tick();
        check_lanes("pre_pause_b", 8'hA1, 1'b1, 8'hA2, 1'b1);
        lane_pause = 1'b1;
        #1;
        check_val("pause_ready", 32'(req_bus.req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_lanes("pause", 8'h00, 1'b0, 8'h00, 1'b0);
            check_val("pause_hold_d0", 32'(lane0_data), 32'hA1);
            check_val("pause_ready",   32'(req_bus.req_ready), 32'h0);
        end
        lane_pause = 1'b0;
        #1;
        check_val("resume_ready", 32'(req_bus.req_ready), 32'b1001);
        tick();
        check_lanes("resume", 8'hA3, 1'b1, 8'hA0, 1'b1);
        check_val("resume_ready", 32'(req_bus.req_ready), 32'b0110);

        // Disable mid-burst and re-enable
        enable = 1'b0;
        #1;
        check_val("dis_ready", 32'(req_bus.req_ready), 32'h0);
        tick();
        check_val("dis_active", 32'(active), 32'h0);
        check_lanes("dis", 8'h00, 1'b0, 8'h00, 1'b0);
        check_val("dis_cnt0", 32'(lane_cnt0), 32'h0);
        enable = 1'b1;
        #1;
        check_val("reen_ready", 32'(req_bus.req_ready), 32'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("reinit_active", 32'(active), 32'h0);
            check_val("reinit_ready",  32'(req_bus.req_ready), 32'h0);
        end
        tick();
        check_val("reup_active", 32'(active), 32'h1);
        check_val("reup_ready",  32'(req_bus.req_ready), 32'b0110);

        // Ten two-lane transfers
        repeat (10) tick();
`ifdef PHY_ARB_STATS_EN
        check_val("stats_cnt0", 32'(lane_cnt0), 32'd10);
        check_val("stats_cnt1", 32'(lane_cnt1), 32'd10);
        repeat (66000) tick();
        check_val("stats_sat0", 32'(lane_cnt0), 32'hFFFF);
        check_val("stats_sat1", 32'(lane_cnt1), 32'hFFFF);
`else
        check_val("nostats_cnt0", 32'(lane_cnt0), 32'h0);
        check_val("nostats_cnt1", 32'(lane_cnt1), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
